// File: rtl/addac_vector_driver.sv
// addac_vector_driver: on-chip stimulus/response engine for the addac accumulator.
// Holds packed 12-bit vectors {clk2, sel0, sel1, a[3:0], cout_exp, s_exp[3:0]},
// drives the stimulus fields into an addac, samples {cout, s} SETTLE cycles later
// and keeps pass/fail statistics with the index of the first failing vector.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   ld_en/ld_addr/ld_data vector memory write port (only while not busy)
//   n_vec, start         run length (clamped to DEPTH) and run request pulse
//   drv_*                stimulus to the addac
//   dut_cout, dut_s      response from the addac
//   busy, done, pass     run status
//   err_count, vec_count saturating error count, vectors checked
//   fail_valid, fail_idx first failing vector capture
//   mismatch             one-cycle pulse for each failing vector
module addac_vector_driver #(
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned AW     = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [11:0]   ld_data,
  input  logic [AW:0]   n_vec,
  input  logic          start,
  output logic          drv_clk2,
  output logic          drv_sel0,
  output logic          drv_sel1,
  output logic [3:0]    drv_a,
  input  logic          dut_cout,
  input  logic [3:0]    dut_s,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW:0]   vec_count,
  output logic          fail_valid,
  output logic [AW-1:0] fail_idx,
  output logic          mismatch
);

  localparam int unsigned SCW     = 4;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef struct packed {
    logic       clk2;
    logic       sel0;
    logic       sel1;
    logic [3:0] a;
  } drv_t;

  typedef struct packed {
    drv_t       drv;
    logic       cout;
    logic [3:0] s;
  } vec_t;

  vec_t           mem_q [DEPTH];
  vec_t           cur;
  logic           ld_we;

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW:0]    n_lat_q, n_lat_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  drv_t           drv_q, drv_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [CW-1:0]  err_q, err_d;
  logic [AW:0]    vec_q, vec_d;
  logic           fv_q, fv_d;
  logic [AW-1:0]  fidx_q, fidx_d;
  logic           mm_q, mm_d;
  logic [AW:0]    n_clamp;

  // Vector memory: writable only when no run is in progress; out-of-range addresses dropped.
  assign ld_we = ld_en && (state_q == S_IDLE || state_q == S_DONE) &&
                 ({1'b0, ld_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= vec_t'(ld_data);
  end

  assign cur     = mem_q[idx_q];
  assign n_clamp = (n_vec > DEPTH_W) ? DEPTH_W : n_vec;

  // Next-state and output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_lat_d = n_lat_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    vec_d   = vec_q;
    fv_d    = fv_q;
    fidx_d  = fidx_q;
    mm_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_lat_d = n_clamp;
          idx_d   = '0;
          err_d   = '0;
          vec_d   = '0;
          fv_d    = 1'b0;
          fidx_d  = '0;
          if (n_clamp == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      S_APPLY: begin
        // Drive changes at the end of APPLY, so CHECK samples exactly SETTLE cycles later.
        drv_d   = cur.drv;
        cnt_d   = SCW'(1);
        state_d = (SETTLE == 1) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SCW'(SETTLE - 1)) state_d = S_CHECK;
        else                           cnt_d   = cnt_q + SCW'(1);
      end
      S_CHECK: begin
        vec_d = vec_q + (AW+1)'(1);
        // Exact 4-state compare: any X/Z from the DUT is a failure.
        if ({dut_cout, dut_s} !== {cur.cout, cur.s}) begin
          mm_d = 1'b1;
          if (err_q != '1) err_d = err_q + CW'(1);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fidx_d = idx_q;
          end
        end
        if ({1'b0, idx_q} == n_lat_q - (AW+1)'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_lat_q <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_lat_q <= n_lat_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
      mm_q    <= mm_d;
    end
  end

  assign drv_clk2   = drv_q.clk2;
  assign drv_sel0   = drv_q.sel0;
  assign drv_sel1   = drv_q.sel1;
  assign drv_a      = drv_q.a;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign vec_count  = vec_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fidx_q;
  assign mismatch   = mm_q;

endmodule

// File: tb/tb_addac_vector_driver.sv
// Bench for addac_vector_driver: two instances (default; CW=2/SETTLE=3) driving
// a behavioural stand-in for the addac, random vectors, expectations from a
// plain-arithmetic scoreboard over the bench's own copy of the vector memory.
module tb_addac_vector_driver;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ld_en, start0, start1, x_en;
  logic [AW-1:0] ld_addr;
  logic [11:0]   ld_data;
  logic [AW:0]   n_vec;

  logic          d0_clk2, d0_sel0, d0_sel1, c0_cout;
  logic [3:0]    d0_a, c0_s;
  logic          busy0, done0, pass0, fv0, mm0;
  logic [7:0]    err0;
  logic [AW:0]   vec0;
  logic [AW-1:0] fidx0;

  logic          d1_clk2, d1_sel0, d1_sel1, c1_cout;
  logic [3:0]    d1_a, c1_s;
  logic          busy1, done1, pass1, fv1, mm1;
  logic [1:0]    err1;
  logic [AW:0]   vec1;
  logic [AW-1:0] fidx1;
  logic [4:0]    r1;

  int n_checks = 0;
  int n_fail   = 0;
  int mm0_tot  = 0;
  int mm1_tot  = 0;
  logic [11:0] mvec [DEPTH];

  // Stand-in addac: {cout, s} = a + 2*{clk2, sel0, sel1}.
  function automatic logic [4:0] addac_f(input logic [6:0] d);
    return {1'b0, d[3:0]} + {1'b0, d[6:4], 1'b0};
  endfunction

  assign {c0_cout, c0_s} = addac_f({d0_clk2, d0_sel0, d0_sel1, d0_a});
  assign r1      = addac_f({d1_clk2, d1_sel0, d1_sel1, d1_a});
  assign c1_cout = r1[4];
  assign c1_s    = x_en ? 4'bxxxx : r1[3:0];

  addac_vector_driver u0 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .n_vec(n_vec), .start(start0), .drv_clk2(d0_clk2), .drv_sel0(d0_sel0),
    .drv_sel1(d0_sel1), .drv_a(d0_a), .dut_cout(c0_cout), .dut_s(c0_s),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
    .fail_valid(fv0), .fail_idx(fidx0), .mismatch(mm0));

  addac_vector_driver #(.SETTLE(3), .CW(2)) u1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .n_vec(n_vec), .start(start1), .drv_clk2(d1_clk2), .drv_sel0(d1_sel0),
    .drv_sel1(d1_sel1), .drv_a(d1_a), .dut_cout(c1_cout), .dut_s(c1_s),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1),
    .fail_valid(fv1), .fail_idx(fidx1), .mismatch(mm1));

  always @(negedge clk) begin
    if (mm0 === 1'b1) mm0_tot <= mm0_tot + 1;
    if (mm1 === 1'b1) mm1_tot <= mm1_tot + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // kind: 0 correct, 1 s wrong, 2 cout and s wrong, 3 correct with s != 0
  function automatic logic [11:0] make_vec(input int kind);
    logic [6:0] d;
    logic [4:0] r;
    d = 7'($urandom);
    r = addac_f(d);
    while (kind == 3 && r[3:0] == 4'd0) begin
      d = 7'($urandom);
      r = addac_f(d);
    end
    if (kind == 1 || kind == 2) r[3:0] = r[3:0] ^ 4'($urandom_range(1, 15));
    if (kind == 2) r[4] = ~r[4];
    return {d, r};
  endfunction

  task automatic load_all();
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = mvec[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Pulse start on one instance and count cycles from the start edge to done.
  task automatic run(input int which, input int n, output int cyc);
    @(negedge clk);
    n_vec = (AW+1)'(n);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; cyc = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (((which == 0) ? done0 : done1) !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if ({busy0, done0, pass0, fv0, mm0} !== 5'b0) begin n_fail++; $display("FAIL reset_flags0: got %b required 00000", {busy0, done0, pass0, fv0, mm0}); end
    n_checks++; if ({err0, vec0, fidx0} !== '0) begin n_fail++; $display("FAIL reset_counts0: got %h required 0", {err0, vec0, fidx0}); end
    n_checks++; if ({d0_clk2, d0_sel0, d0_sel1, d0_a} !== 7'b0) begin n_fail++; $display("FAIL reset_drv0: got %h required 0", {d0_clk2, d0_sel0, d0_sel1, d0_a}); end
    n_checks++; if ({busy1, done1, pass1, fv1, mm1, err1, vec1, fidx1} !== '0) begin n_fail++; $display("FAIL reset_all1: got %h required 0", {busy1, done1, pass1, fv1, mm1, err1, vec1, fidx1}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run n vectors on u0 and compare every status output with the scoreboard.
  task automatic test_run_scenario(input string name, input int n);
    int nl, exp_err, exp_first, cyc, mm_before;
    nl = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    exp_err = 0; exp_first = -1;
    for (int i = 0; i < nl; i++)
      if (mvec[i][4:0] != addac_f(mvec[i][11:5])) begin
        exp_err++;
        if (exp_first < 0) exp_first = i;
      end
    mm_before = mm0_tot;
    run(0, n, cyc);
    @(posedge clk); #1;
    n_checks++; if (cyc != nl * 2) begin n_fail++; $display("FAIL %s_cycles: got %0d required %0d", name, cyc, nl * 2); end
    n_checks++; if (err0 !== 8'(exp_err)) begin n_fail++; $display("FAIL %s_err: got %0d required %0d", name, err0, exp_err); end
    n_checks++; if (vec0 !== (AW+1)'(nl)) begin n_fail++; $display("FAIL %s_vec: got %0d required %0d", name, vec0, nl); end
    n_checks++; if (pass0 !== (exp_err == 0)) begin n_fail++; $display("FAIL %s_pass: got %b required %b", name, pass0, exp_err == 0); end
    n_checks++; if ({busy0, done0} !== 2'b01) begin n_fail++; $display("FAIL %s_busy_done: got %b required 01", name, {busy0, done0}); end
    n_checks++; if (fv0 !== (exp_err > 0)) begin n_fail++; $display("FAIL %s_fail_valid: got %b required %b", name, fv0, exp_err > 0); end
    n_checks++; if (fidx0 !== AW'((exp_first < 0) ? 0 : exp_first)) begin n_fail++; $display("FAIL %s_fail_idx: got %0d required %0d", name, fidx0, (exp_first < 0) ? 0 : exp_first); end
    n_checks++; if (mm0_tot - mm_before != exp_err) begin n_fail++; $display("FAIL %s_pulses: got %0d required %0d", name, mm0_tot - mm_before, exp_err); end
    if (nl > 0) begin
      n_checks++; if ({d0_clk2, d0_sel0, d0_sel1, d0_a} !== mvec[nl-1][11:5]) begin n_fail++; $display("FAIL %s_drv_hold: got %h required %h", name, {d0_clk2, d0_sel0, d0_sel1, d0_a}, mvec[nl-1][11:5]); end
    end
  endtask

  task automatic test_pass_run();
    for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec(0);
    load_all();
    test_run_scenario("pass11", 11);
  endtask

  task automatic test_corrupt();
    for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec((i == 3 || i == 7) ? 1 : 0);
    load_all();
    test_run_scenario("corrupt_3_7", 11);
    for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec((i == 5) ? 2 : 0);
    load_all();
    test_run_scenario("both_fields", 11);
  endtask

  task automatic test_random_errors();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec(int'($urandom_range(0, 3)) % 3);
      load_all();
      test_run_scenario("random", int'($urandom_range(1, 15)));
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec(0);
    load_all();
    test_run_scenario("nvec0", 0);
    test_run_scenario("nvec20", 20);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    n_vec = (AW+1)'(11); start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; cyc = 0;
    while (done0 !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      ld_en = 1'b0; start0 = 1'b0;
      if (cyc == 5) begin ld_en = 1'b1; ld_addr = AW'(2); ld_data = ~mvec[2]; start0 = 1'b1; n_vec = (AW+1)'(3); end
      if (cyc == 9) begin ld_en = 1'b1; ld_addr = AW'(7); ld_data = ~mvec[7]; end
    end
    ld_en = 1'b0; start0 = 1'b0;
    n_checks++; if (cyc != 22) begin n_fail++; $display("FAIL busy_cycles: got %0d required 22", cyc); end
    n_checks++; if ({vec0, err0, pass0} !== {5'd11, 8'd0, 1'b1}) begin n_fail++; $display("FAIL busy_result: vec %0d err %0d pass %b required 11 0 1", vec0, err0, pass0); end
    test_run_scenario("mem_kept", 11);
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    n_vec = (AW+1)'(11); start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; cyc = 0;
    while (vec0 !== (AW+1)'(5) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL mid_vec5_time: got %0d required 10", cyc); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({busy0, done0, pass0, fv0, mm0, err0, vec0, fidx0} !== '0) begin n_fail++; $display("FAIL mid_reset_status: got %h required 0", {busy0, done0, pass0, fv0, mm0, err0, vec0, fidx0}); end
    n_checks++; if ({d0_clk2, d0_sel0, d0_sel1, d0_a} !== 7'b0) begin n_fail++; $display("FAIL mid_reset_drv: got %h required 0", {d0_clk2, d0_sel0, d0_sel1, d0_a}); end
    @(negedge clk);
    rst = 1'b1;
    test_run_scenario("after_reset", 11);
  endtask

  task automatic test_x_saturate();
    int cyc, mm_before, nx, exp_err;
    for (int i = 0; i < int'(DEPTH); i++) mvec[i] = make_vec(3);
    load_all();
    x_en = 1'b1;
    nx = 5;
    exp_err = (nx > 3) ? 3 : nx;
    mm_before = mm1_tot;
    run(1, nx, cyc);
    @(posedge clk); #1;
    x_en = 1'b0;
    n_checks++; if (cyc != nx * 4) begin n_fail++; $display("FAIL x_cycles: got %0d required %0d", cyc, nx * 4); end
    n_checks++; if (err1 !== 2'(exp_err)) begin n_fail++; $display("FAIL x_err_sat: got %0d required %0d", err1, exp_err); end
    n_checks++; if ({vec1, fv1, fidx1, pass1} !== {5'(nx), 1'b1, 4'd0, 1'b0}) begin n_fail++; $display("FAIL x_status: vec %0d fv %b idx %0d pass %b", vec1, fv1, fidx1, pass1); end
    n_checks++; if (mm1_tot - mm_before != nx) begin n_fail++; $display("FAIL x_pulses: got %0d required %0d", mm1_tot - mm_before, nx); end
    run(1, 11, cyc);
    @(posedge clk); #1;
    n_checks++; if (cyc != 44) begin n_fail++; $display("FAIL settle3_cycles: got %0d required 44", cyc); end
    n_checks++; if ({err1, pass1, vec1, fv1} !== {2'd0, 1'b1, 5'd11, 1'b0}) begin n_fail++; $display("FAIL settle3_status: err %0d pass %b vec %0d fv %b", err1, pass1, vec1, fv1); end
    n_checks++; if ({d1_clk2, d1_sel0, d1_sel1, d1_a} !== mvec[10][11:5]) begin n_fail++; $display("FAIL settle3_drv: got %h required %h", {d1_clk2, d1_sel0, d1_sel1, d1_a}, mvec[10][11:5]); end
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; n_vec = '0;
    start0 = 1'b0; start1 = 1'b0; x_en = 1'b0;
    test_reset();
    test_pass_run();
    test_corrupt();
    test_clamp();
    test_busy_ignore();
    test_reset_mid();
    test_random_errors();
    test_x_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addac_vector_driver.md
Name: addac_vector_driver

Overview:
- Synthesizable stimulus/response engine for the addac accumulator: the driving-and-checking end of the addac vector interface.
- Holds packed 12-bit test vectors in a write-loaded memory, drives {clk2, sel0, sel1, a} into an addac instance, and compares its {cout, s} against the expected fields.
- Accumulates error statistics and captures the first failing index, so the addac can be self-tested on-chip without a file-based bench.

Parameters:
- DEPTH, 11, number of vector memory entries (1..2**AW).
- AW, 4, vector address width.
- SETTLE, 1, cycles between applying a vector and sampling DUT outputs (1..15).
- CW, 8, error counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  vector write strobe.
- ld_addr  in  AW  vector write address.
- ld_data  in  12  packed vector {clk2, sel0, sel1, a[3:0], cout_exp, s_exp[3:0]}, MSB first.
- n_vec  in  AW+1  number of vectors to run; sampled on accepted start.
- start  in  1  run request, single-cycle pulse.
- drv_clk2  out  1  to addac clk2.
- drv_sel0  out  1  to addac sel0.
- drv_sel1  out  1  to addac sel1.
- drv_a  out  4  to addac a.
- dut_cout  in  1  from addac cout.
- dut_s  in  4  from addac s.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next accepted start.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  CW  mismatch count; saturates at 2**CW-1.
- vec_count  out  AW+1  vectors checked so far.
- fail_valid  out  1  a first failure has been captured.
- fail_idx  out  AW  index of the first failing vector.
- mismatch  out  1  one-cycle pulse in the CHECK cycle of a failing vector.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; memory contents unchanged/undefined.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- Memory load:
  - ld_en writes ld_data to mem[ld_addr] at posedge, accepted only in IDLE or DONE.
  - Ignored while busy.
  - ld_addr >= DEPTH is ignored.
- Start acceptance:
  - start in IDLE/DONE is accepted: latch n_vec (clamped to DEPTH), clear err_count, vec_count, fail_valid, fail_idx, done, pass; idx=0.
  - Next state is APPLY, or DONE with pass=1 if the clamped n_vec==0.
  - start while busy is ignored.
- APPLY (1 cycle): drive outputs registered from mem[idx] fields; busy=1.
- SETTLE: waits SETTLE-1 further cycles, so the DUT is sampled exactly SETTLE cycles after the drive outputs change.
  - If SETTLE==1, goes straight to CHECK.
- CHECK (1 cycle):
  - Compare dut_cout and dut_s against cout_exp and s_exp using 4-state exact match; X/Z on any DUT bit counts as a mismatch.
  - Either field mismatching counts as one error per vector (not per bit).
  - On mismatch: mismatch=1; err_count++ (saturating); if !fail_valid, capture fail_idx=idx and set fail_valid=1.
  - vec_count++.
  - If idx==n_lat-1 go to DONE, else idx++ and go to APPLY.
- Drive outputs hold their last value through SETTLE/CHECK and after DONE.
- DONE: busy=0, done=1, pass=(err_count==0). Stays until next accepted start.
- Per-vector latency = 1 + SETTLE cycles. Total run = n*(1+SETTLE) cycles from the start edge to done rising.
- Reset mid-run: immediate return to IDLE, all counters/flags cleared, drive outputs forced to 0.

Test Plan:
- Load 11 vectors matching a correct addac; start with n_vec=11, SETTLE=1 -> done after 22 cycles, pass=1, err_count=0, vec_count=11, fail_valid=0.
- Corrupt s_exp of vectors 3 and 7 -> err_count=2, fail_idx=3, fail_valid=1, pass=0, exactly two mismatch pulses.
- Vector with both cout and s wrong -> err_count increments by 1 only.
- n_vec=0 -> done=1, pass=1 the cycle after start; n_vec=20 -> clamped, vec_count=11.
- ld_en and start pulses during a run -> memory unchanged, run unaffected; rst=0 at vector 5 -> all outputs 0 immediately, and a new start runs from index 0.
- DUT driving s=4'bx, CW=2 with 5 failing vectors -> each X vector counts as an error; err_count saturates at 3.
